mem_req_arbiter: RTL and testbench

Arbitrates instruction-fetch reads, LSU loads and LSU stores onto the single read port and single write port of the direct-mapped cache controller. It sits directly upstream of the cache controller's arbiter-side interface. It guarantees that a read and a write to the same word are never issued in the same cycle. Read data returns from the cache after a fixed latency and is routed back to the requester that issued it.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_resp_pipe.sv | 37 +++
 rtl/mem_req_arbiter.sv | 115 +++++++++++
 tb/tb_mem_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_arb_pkg;

    typedef enum logic {SRC_IF, SRC_LD} req_src_e;

    typedef struct packed {
        logic     valid;
        req_src_e src;
    } rd_tag_t;

    localparam int WORD_LSB = 2;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Fixed-depth shift register carrying {valid, src} for each issued read so the
// returning cache data can be steered back to the requester that issued it.
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic    clk_i,
    input  logic    clr_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [Depth-1:0] pipe_q;
    rd_tag_t [Depth-1:0] pipe_d;

    if (Depth > 1) begin : g_shift
        always_comb begin
            pipe_d = {pipe_q[Depth-2:0], tag_i};
        end
    end else begin : g_single
        always_comb begin
            pipe_d = tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch/load reads and stores onto the cache controller read/write ports.
// Define ARB_RR_EN for round-robin fetch/load arbitration; otherwise load has fixed priority.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,

    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_req_ready,
    output logic              ld_resp_valid,
    output logic [DATA_W-1:0] ld_resp_data,

    input  logic              st_req_valid,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    output logic              st_req_ready,

    output logic              arb_raddr_valid,
    output logic [ADDR_W-1:0] arb_raddr,
    input  logic [DATA_W-1:0] arb_rdata,
    output logic              arb_waddr_valid,
    output logic [ADDR_W-1:0] arb_waddr,
    output logic [DATA_W-1:0] arb_wdata,
    input  logic              arb_stall
);

    logic              rd_want;
    logic              grant_ld;
    logic              st_issue;
    logic              word_clash;
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    rd_tag_t           issue_tag;
    rd_tag_t           resp_tag;

`ifdef ARB_RR_EN
    req_src_e last_grant_q;
    req_src_e last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (rd_issue) begin
            last_grant_d = grant_ld ? SRC_LD : SRC_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SRC_LD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Grant is chosen first; a same-word store then blocks it for this cycle.
    always_comb begin
        rd_want = if_req_valid | ld_req_valid;
`ifdef ARB_RR_EN
        grant_ld = ld_req_valid & (~if_req_valid | (last_grant_q == SRC_IF));
`else
        grant_ld = ld_req_valid;
`endif
        rd_addr    = grant_ld ? ld_req_addr : if_req_addr;
        st_issue   = st_req_valid & ~arb_stall & ~rst;
        word_clash = st_issue
                   & (rd_addr[ADDR_W-1:WORD_LSB] == st_req_addr[ADDR_W-1:WORD_LSB]);
        rd_issue   = rd_want & ~arb_stall & ~rst & ~word_clash;
    end

    always_comb begin
        if_req_ready    = rd_issue & ~grant_ld;
        ld_req_ready    = rd_issue & grant_ld;
        st_req_ready    = st_issue;
        arb_raddr_valid = rd_issue;
        arb_raddr       = rd_issue ? rd_addr : '0;
        arb_waddr_valid = st_issue;
        arb_waddr       = st_issue ? st_req_addr : '0;
        arb_wdata       = st_issue ? st_req_data : '0;
    end

    always_comb begin
        issue_tag.valid = rd_issue;
        issue_tag.src   = grant_ld ? SRC_LD : SRC_IF;
    end

    mem_arb_resp_pipe #(
        .Depth (READ_LAT)
    ) u_resp_pipe (
        .clk_i (clk),
        .clr_i (rst),
        .tag_i (issue_tag),
        .tag_o (resp_tag)
    );

    always_comb begin
        if_resp_valid = resp_tag.valid & (resp_tag.src == SRC_IF) & ~rst;
        ld_resp_valid = resp_tag.valid & (resp_tag.src == SRC_LD) & ~rst;
        if_resp_data  = if_resp_valid ? arb_rdata : '0;
        ld_resp_data  = ld_resp_valid ? arb_rdata : '0;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized bench for mem_req_arbiter against a transaction-level model.
module tb_mem_req_arbiter;

    localparam int READ_LAT = 2;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid, if_req_ready, if_resp_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic [DATA_W-1:0] if_resp_data;
    logic              ld_req_valid, ld_req_ready, ld_resp_valid;
    logic [ADDR_W-1:0] ld_req_addr;
    logic [DATA_W-1:0] ld_resp_data;
    logic              st_req_valid, st_req_ready;
    logic [ADDR_W-1:0] st_req_addr;
    logic [DATA_W-1:0] st_req_data;
    logic              arb_raddr_valid, arb_waddr_valid, arb_stall;
    logic [ADDR_W-1:0] arb_raddr, arb_waddr;
    logic [DATA_W-1:0] arb_rdata, arb_wdata;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .READ_LAT (READ_LAT),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req_valid    (if_req_valid),
        .if_req_addr     (if_req_addr),
        .if_req_ready    (if_req_ready),
        .if_resp_valid   (if_resp_valid),
        .if_resp_data    (if_resp_data),
        .ld_req_valid    (ld_req_valid),
        .ld_req_addr     (ld_req_addr),
        .ld_req_ready    (ld_req_ready),
        .ld_resp_valid   (ld_resp_valid),
        .ld_resp_data    (ld_resp_data),
        .st_req_valid    (st_req_valid),
        .st_req_addr     (st_req_addr),
        .st_req_data     (st_req_data),
        .st_req_ready    (st_req_ready),
        .arb_raddr_valid (arb_raddr_valid),
        .arb_raddr       (arb_raddr),
        .arb_rdata       (arb_rdata),
        .arb_waddr_valid (arb_waddr_valid),
        .arb_waddr       (arb_waddr),
        .arb_wdata       (arb_wdata),
        .arb_stall       (arb_stall)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: a list of outstanding reads, each with its due cycle and owner.
    typedef struct {
        int due;
        bit is_ld;
    } resp_t;

    resp_t m_q[$];
    bit    m_last_ld;
    bit    m_pick_ld;
    int    cyc = 0;

    logic              e_if_rdy, e_ld_rdy, e_st_rdy, e_rv, e_wv, e_ifv, e_ldv;
    logic [ADDR_W-1:0] e_raddr, e_waddr;
    logic [DATA_W-1:0] e_wdata, e_ifd, e_ldd;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit          st_go, rd_any, clash;
        logic [31:0] ra;
        {e_if_rdy, e_ld_rdy, e_st_rdy, e_rv, e_wv, e_ifv, e_ldv} = '0;
        e_raddr = '0; e_waddr = '0; e_wdata = '0; e_ifd = '0; e_ldd = '0;
        m_pick_ld = 1'b0;
        if (!rst) begin
            st_go  = st_req_valid && !arb_stall;
            rd_any = if_req_valid || ld_req_valid;
`ifdef ARB_RR_EN
            m_pick_ld = ld_req_valid && (!if_req_valid || !m_last_ld);
`else
            m_pick_ld = ld_req_valid;
`endif
            ra    = m_pick_ld ? ld_req_addr : if_req_addr;
            clash = st_go && rd_any && ((ra >> 2) == (st_req_addr >> 2));
            if (st_go) begin
                e_st_rdy = 1'b1; e_wv = 1'b1;
                e_waddr = st_req_addr; e_wdata = st_req_data;
            end
            if (rd_any && !arb_stall && !clash) begin
                e_rv = 1'b1; e_raddr = ra;
                e_if_rdy = !m_pick_ld; e_ld_rdy = m_pick_ld;
            end
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                if (m_q[0].is_ld) begin e_ldv = 1'b1; e_ldd = arb_rdata; end
                else              begin e_ifv = 1'b1; e_ifd = arb_rdata; end
            end
        end
    endtask

    task automatic model_commit();
        resp_t r;
        if (rst) begin
            m_q.delete();
            m_last_ld = 1'b1;
        end else begin
            if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
            if (e_rv) begin
                r.due = cyc + READ_LAT; r.is_ld = m_pick_ld;
                m_q.push_back(r);
                m_last_ld = m_pick_ld;
            end
            // Requesters drop valid once accepted.
            if (e_if_rdy) if_req_valid = 1'b0;
            if (e_ld_rdy) ld_req_valid = 1'b0;
            if (e_st_rdy) st_req_valid = 1'b0;
        end
        cyc++;
    endtask

    task automatic settle();
        #1;
        model_eval();
        check1 ("if_req_ready",    if_req_ready,    e_if_rdy);
        check1 ("ld_req_ready",    ld_req_ready,    e_ld_rdy);
        check1 ("st_req_ready",    st_req_ready,    e_st_rdy);
        check1 ("arb_raddr_valid", arb_raddr_valid, e_rv);
        check32("arb_raddr",       arb_raddr,       e_raddr);
        check1 ("arb_waddr_valid", arb_waddr_valid, e_wv);
        check32("arb_waddr",       arb_waddr,       e_waddr);
        check32("arb_wdata",       arb_wdata,       e_wdata);
        check1 ("if_resp_valid",   if_resp_valid,   e_ifv);
        check32("if_resp_data",    if_resp_data,    e_ifd);
        check1 ("ld_resp_valid",   ld_resp_valid,   e_ldv);
        check32("ld_resp_data",    ld_resp_data,    e_ldd);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            arb_rdata = $urandom;
            settle();
            adv();
        end
    endtask

    initial begin
        rst = 1'b1;
        {if_req_valid, ld_req_valid, st_req_valid, arb_stall} = '0;
        if_req_addr = '0; ld_req_addr = '0; st_req_addr = '0; st_req_data = '0;
        arb_rdata = '0;
        tick(2);
        rst = 1'b0;

        // Fetch-only read with known return data.
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
        settle();
        check1("t1 if ready", if_req_ready, 1'b1);
        adv();
        tick(READ_LAT - 1);
        arb_rdata = 32'hDEAD_BEEF;
        settle();
        check1 ("t1 if resp valid", if_resp_valid, 1'b1);
        check32("t1 if resp data",  if_resp_data,  32'hDEAD_BEEF);
        check1 ("t1 ld resp valid", ld_resp_valid, 1'b0);
        adv();

        // Reset one cycle after a read issue discards it.
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0020;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < READ_LAT + 1; i++) begin
            arb_rdata = $urandom;
            settle();
            check1("t6 no if resp", if_resp_valid, 1'b0);
            check1("t6 no ld resp", ld_resp_valid, 1'b0);
            adv();
        end

        // Continuous fetch/load contention from reset state.
        if_req_addr = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            if_req_valid = 1'b1;
            ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0300 + 32'(k * 4);
            arb_rdata = $urandom;
            settle();
`ifdef ARB_RR_EN
            check1("t2 rr if ready", if_req_ready, (k % 2) == 0);
            check1("t2 rr ld ready", ld_req_ready, (k % 2) == 1);
`else
            check1("t2 fp if ready", if_req_ready, 1'b0);
            check1("t2 fp ld ready", ld_req_ready, 1'b1);
`endif
            adv();
        end
        if_req_valid = 1'b0; ld_req_valid = 1'b0;
        tick(READ_LAT + 1);

        // Same-word store and load: store first, load next cycle.
        st_req_valid = 1'b1; st_req_addr = 32'h0000_0100; st_req_data = 32'hA5A5_0001;
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0102;
        settle();
        check1("t3 st ready",   st_req_ready,    1'b1);
        check1("t3 ld blocked", ld_req_ready,    1'b0);
        check1("t3 no rd",      arb_raddr_valid, 1'b0);
        adv();
        settle();
        check1("t3 ld retry", ld_req_ready, 1'b1);
        adv();
        tick(READ_LAT - 1);
        settle();
        check1("t3 ld resp", ld_resp_valid, 1'b1);
        adv();

        // Different words issue together.
        st_req_valid = 1'b1; st_req_addr = 32'h0000_0100; st_req_data = 32'h1234_5678;
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0104;
        settle();
        check1("t4 rd issue", arb_raddr_valid, 1'b1);
        check1("t4 wr issue", arb_waddr_valid, 1'b1);
        adv();
        tick(READ_LAT + 1);

        // Stall for 3 cycles with a read in flight.
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0040;
        tick(1);
        arb_stall = 1'b1;
        st_req_valid = 1'b1; st_req_addr = 32'h0000_0080; st_req_data = 32'h0BAD_F00D;
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0044;
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0048;
        for (int s = 0; s < 3; s++) begin
            arb_rdata = $urandom;
            settle();
            check1("t5 if ready", if_req_ready, 1'b0);
            check1("t5 ld ready", ld_req_ready, 1'b0);
            check1("t5 st ready", st_req_ready, 1'b0);
            if (s == READ_LAT - 1) check1("t5 inflight resp", if_resp_valid, 1'b1);
            adv();
        end
        arb_stall = 1'b0;
        tick(4);
        if_req_valid = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
        tick(READ_LAT + 1);

        // Randomized traffic on a small address window to provoke same-word clashes.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            arb_stall = ($urandom_range(0, 99) < 15);
            if (!if_req_valid && $urandom_range(0, 1) == 1) begin
                if_req_valid = 1'b1;
                if_req_addr  = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            end
            if (!ld_req_valid && $urandom_range(0, 1) == 1) begin
                ld_req_valid = 1'b1;
                ld_req_addr  = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            end
            if (!st_req_valid && $urandom_range(0, 2) == 0) begin
                st_req_valid = 1'b1;
                st_req_addr  = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                st_req_data  = $urandom;
            end
            tick(1);
        end
        rst = 1'b0; arb_stall = 1'b0;
        if_req_valid = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
        tick(READ_LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
